exec_state_ctrl: RTL and testbench

EXEC_STATE_CTRL -- requirements
Module: exec_state_ctrl

---
 rtl/exec_state_pkg.sv | 12 +
 rtl/exec_state_ctrl_thr_compare.sv | 23 ++
 rtl/exec_state_ctrl.sv | 108 ++++++++++
 tb/tb_exec_state_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/exec_state_pkg.sv
// exec_state_pkg: shared state encoding and trigger offset helper
package exec_state_pkg;
  typedef enum logic [1:0] {
    INIT    = 2'b00,
    ACQUIRE = 2'b01,
    HOLD    = 2'b10,
    TRG     = 2'b11
  } exec_state_t;
  function automatic int calc_offset(input int threshold);
    return (threshold * 4096) / 100;
  endfunction
endpackage

// File: rtl/exec_state_ctrl_thr_compare.sv
// thr_compare: splits a beat into signed samples and flags any sample above the threshold
module thr_compare
  import exec_state_pkg::*;
#(
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128
) (
  input  logic [S_AXIS_TDATA_WIDTH-1:0]          tdata,
  input  logic signed [ADC_RESOLUTION_WIDTH+1:0] threshold,
  output logic                                   any_above
);
  localparam int W = ADC_RESOLUTION_WIDTH;
  localparam int N = S_AXIS_TDATA_WIDTH / 16;
  logic [N-1:0] above;
  logic         unused_pad;
  for (genvar i = 0; i < N; i++) begin : g_smp
    logic signed [W+1:0] s;
    assign s        = {{2{tdata[16*i+W-1]}}, tdata[16*i +: W]};
    assign above[i] = s > threshold;
  end
  assign any_above  = |above;
  assign unused_pad = ^tdata;
endmodule

// File: rtl/exec_state_ctrl.sv
// exec_state_ctrl: INIT/ACQUIRE/TRG/HOLD trigger controller
// optional periodic recalibration enabled by EXEC_STATE_RECALIB_EN
module exec_state_ctrl
  import exec_state_pkg::*;
#(
  parameter int THRESHOLD            = 10,
  parameter int BASELINE_CALC_LEN    = 500000000,
  parameter int POST_TRG_LEN         = 16,
  parameter int RECALIB_INTERVAL     = 1000000000,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128
) (
  input  logic                                   AXIS_ACLK,
  input  logic                                   AXIS_ARESETN,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
  input  logic                                   S_AXIS_TVALID,
  input  logic [ADC_RESOLUTION_WIDTH-1:0]        I_BASELINE,
  input  logic                                   I_CALC_COMPLETE,
  output logic [1:0]                             EXEC_STATE,
  output logic                                   O_TRIGGER,
  output logic signed [ADC_RESOLUTION_WIDTH+1:0] O_THRESHOLD_VAL,
  output logic [31:0]                            O_TRG_CNT
);
  localparam int W  = ADC_RESOLUTION_WIDTH;
  localparam int IW = $clog2(BASELINE_CALC_LEN + 1);
  localparam int PW = $clog2(POST_TRG_LEN + 1);
  localparam logic [W+1:0] OFF = (W+2)'(calc_offset(THRESHOLD));
  exec_state_t st;
  logic          hit;
  logic          above;
  logic [IW-1:0] init_cnt;
  logic [PW-1:0] post_cnt;
`ifdef EXEC_STATE_RECALIB_EN
  localparam int RW = $clog2(RECALIB_INTERVAL + 1);
  logic [RW-1:0] idle_cnt;
`else
  localparam int unused_recalib = RECALIB_INTERVAL;
`endif
  thr_compare #(
    .ADC_RESOLUTION_WIDTH(ADC_RESOLUTION_WIDTH),
    .S_AXIS_TDATA_WIDTH  (S_AXIS_TDATA_WIDTH)
  ) u_cmp (
    .tdata    (S_AXIS_TDATA),
    .threshold(O_THRESHOLD_VAL),
    .any_above(above)
  );
  assign EXEC_STATE = st;
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      st              <= INIT;
      hit             <= 1'b0;
      O_TRIGGER       <= 1'b0;
      O_THRESHOLD_VAL <= '0;
      O_TRG_CNT       <= '0;
      init_cnt        <= '0;
      post_cnt        <= '0;
`ifdef EXEC_STATE_RECALIB_EN
      idle_cnt        <= '0;
`endif
    end else begin
      hit       <= S_AXIS_TVALID & above;
      O_TRIGGER <= 1'b0;
      case (st)
        INIT: begin
          init_cnt <= !S_AXIS_TVALID ? '0 :
                      (init_cnt >= IW'(BASELINE_CALC_LEN)) ? init_cnt : init_cnt + 1'b1;
          if (init_cnt >= IW'(BASELINE_CALC_LEN) && I_CALC_COMPLETE) begin
            st              <= ACQUIRE;
            O_THRESHOLD_VAL <= {{2{I_BASELINE[W-1]}}, I_BASELINE} + OFF;
          end
        end
        ACQUIRE: begin
          // a pending hit takes priority over a coinciding recalibration expiry
          if (hit) begin
            st        <= TRG;
            O_TRIGGER <= 1'b1;
            O_TRG_CNT <= O_TRG_CNT + 1'b1;
`ifdef EXEC_STATE_RECALIB_EN
            idle_cnt  <= '0;
`endif
          end
`ifdef EXEC_STATE_RECALIB_EN
          else if (idle_cnt == RW'(RECALIB_INTERVAL - 1)) begin
            st       <= INIT;
            init_cnt <= '0;
            idle_cnt <= '0;
          end else
            idle_cnt <= idle_cnt + 1'b1;
`endif
        end
        TRG: begin
          if (!hit) begin
            st       <= HOLD;
            post_cnt <= PW'(POST_TRG_LEN - 1);
          end
        end
        HOLD: begin
          if (hit)
            st <= TRG;
          else if (post_cnt == '0)
            st <= ACQUIRE;
          else
            post_cnt <= post_cnt - 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exec_state_ctrl.sv
// tb_exec_state_ctrl: directed and randomized checks against a behavioural trigger model
module tb_exec_state_ctrl;
  localparam int W = 12, DW = 128, N = DW / 16;
  localparam int THR = 10, LEN = 8, POST = 4, RI = 20;
  localparam int S_INIT = 0, S_ACQ = 1, S_HOLD = 2, S_TRG = 3;
  logic          AXIS_ACLK = 1'b0;
  logic          AXIS_ARESETN = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic          S_AXIS_TVALID = 1'b0;
  logic [W-1:0]  I_BASELINE = '0;
  logic          I_CALC_COMPLETE = 1'b0;
  logic [1:0]    EXEC_STATE;
  logic          O_TRIGGER;
  logic [W+1:0]  O_THRESHOLD_VAL;
  logic [31:0]   O_TRG_CNT;
  int n_chk = 0, n_fail = 0;
  int smp[N];
  int base = 100;
  bit valid = 0, comp = 0, rstn = 0;
  int m_st, m_thr, m_trig, m_hit, m_init, m_hold, m_idle;
  logic [31:0] m_cnt;

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  exec_state_ctrl #(
    .THRESHOLD(THR), .BASELINE_CALC_LEN(LEN), .POST_TRG_LEN(POST),
    .RECALIB_INTERVAL(RI), .ADC_RESOLUTION_WIDTH(W), .S_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .I_BASELINE(I_BASELINE), .I_CALC_COMPLETE(I_CALC_COMPLETE),
    .EXEC_STATE(EXEC_STATE), .O_TRIGGER(O_TRIGGER),
    .O_THRESHOLD_VAL(O_THRESHOLD_VAL), .O_TRG_CNT(O_TRG_CNT)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    bit nh = 0;
    for (int i = 0; i < N; i++) if (valid && smp[i] > m_thr) nh = 1;
    if (!rstn) begin
      m_st = S_INIT; m_thr = 0; m_cnt = 0; m_trig = 0;
      m_hit = 0; m_init = 0; m_hold = 0; m_idle = 0;
      return;
    end
    m_trig = 0;
    case (m_st)
      S_INIT: begin
        if (m_init >= LEN && comp) begin
          m_st = S_ACQ; m_thr = base + (THR * 4096) / 100; m_idle = 0;
        end
        m_init = valid ? ((m_init < LEN) ? m_init + 1 : LEN) : 0;
      end
      S_ACQ: begin
        if (m_hit) begin
          m_st = S_TRG; m_trig = 1; m_cnt = m_cnt + 1;
        end else begin
`ifdef EXEC_STATE_RECALIB_EN
          m_idle++;
          if (m_idle == RI) begin m_st = S_INIT; m_init = 0; end
`endif
        end
      end
      S_TRG: if (!m_hit) begin m_st = S_HOLD; m_hold = 0; end
      default: begin
        if (m_hit) m_st = S_TRG;
        else begin
          m_hold++;
          if (m_hold == POST) begin m_st = S_ACQ; m_idle = 0; end
        end
      end
    endcase
    m_hit = nh;
  endtask

  task automatic cyc();
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[16*i +: 16] = {4'($urandom), 12'(smp[i])};
    S_AXIS_TDATA    = d;
    S_AXIS_TVALID   = valid;
    I_BASELINE      = 12'(base);
    I_CALC_COMPLETE = comp;
    AXIS_ARESETN    = rstn;
    @(posedge AXIS_ACLK);
    model();
    #1;
    check("state", EXEC_STATE, m_st);
    check("trigger", O_TRIGGER, m_trig);
    check("threshold", $signed(O_THRESHOLD_VAL), m_thr);
    check("trg_cnt", O_TRG_CNT, m_cnt);
  endtask

  task automatic zero_smp();
    for (int i = 0; i < N; i++) smp[i] = 0;
  endtask

  task automatic beat(input int v3);
    zero_smp(); smp[3] = v3; valid = 1; cyc(); valid = 0; zero_smp();
  endtask

  initial begin
    zero_smp();
    repeat (2) cyc();
    check("reset_state", EXEC_STATE, S_INIT);
    check("reset_cnt", O_TRG_CNT, 0);
    rstn = 1; comp = 1; base = 100;
    valid = 1; repeat (4) cyc();
    valid = 0; cyc();
    valid = 1; repeat (8) cyc();
    check("init_restart_not_yet", EXEC_STATE, S_INIT);
    cyc();
    check("acquire_entry", EXEC_STATE, S_ACQ);
    check("threshold_509", $signed(O_THRESHOLD_VAL), 509);
    valid = 0;
    beat(509); repeat (3) cyc();
    check("equal_no_trigger", O_TRG_CNT, 0);
    beat(510);
    check("hit_one_cycle_later", EXEC_STATE, S_ACQ);
    cyc();
    check("trg_two_cycles", EXEC_STATE, S_TRG);
    check("trg_pulse", O_TRIGGER, 1);
    check("trg_cnt_1", O_TRG_CNT, 1);
    for (int k = 0; k < POST; k++) begin
      cyc();
      check("hold_dwell", EXEC_STATE, S_HOLD);
    end
    cyc();
    check("hold_to_acq", EXEC_STATE, S_ACQ);
    beat(600); cyc(); cyc();
    check("hold_c1", EXEC_STATE, S_HOLD);
    beat(700);
    check("hold_c2", EXEC_STATE, S_HOLD);
    cyc();
    check("hold_retrg_state", EXEC_STATE, S_TRG);
    check("hold_retrg_no_pulse", O_TRIGGER, 0);
    check("hold_retrg_cnt", O_TRG_CNT, 2);
    repeat (6) cyc();
    for (int c = 0; c < 600; c++) begin
      rstn  = $urandom_range(0, 149) != 0;
      valid = $urandom_range(0, 3) != 0;
      comp  = $urandom_range(0, 3) != 0;
      base  = int'($urandom_range(0, 4095)) - 2048;
      for (int i = 0; i < N; i++) begin
        int v;
        v = ($urandom_range(0, 7) == 0) ? m_thr + int'($urandom_range(0, 4)) - 2
                                         : int'($urandom_range(0, 4095)) - 2048;
        smp[i] = (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
      end
      cyc();
    end
    zero_smp(); valid = 0; comp = 1; base = 100;
    rstn = 0; cyc();
    rstn = 1; valid = 1; repeat (9) cyc(); valid = 0;
    check("reacq", EXEC_STATE, S_ACQ);
    beat(510); cyc(); cyc(); cyc();
    check("pre_reset_hold", EXEC_STATE, S_HOLD);
    rstn = 0; cyc();
    check("rst_hold_state", EXEC_STATE, S_INIT);
    check("rst_hold_trig", O_TRIGGER, 0);
    check("rst_hold_thr", O_THRESHOLD_VAL, 0);
    check("rst_hold_cnt", O_TRG_CNT, 0);
    rstn = 1;
`ifdef EXEC_STATE_RECALIB_EN
    valid = 1; repeat (9) cyc(); valid = 0;
    repeat (RI - 1) cyc();
    check("recal_before", EXEC_STATE, S_ACQ);
    cyc();
    check("recal_init", EXEC_STATE, S_INIT);
    valid = 1; repeat (9) cyc(); valid = 0;
    repeat (RI - 2) cyc();
    beat(510);
    cyc();
    check("recal_hit_wins", EXEC_STATE, S_TRG);
    check("recal_hit_pulse", O_TRIGGER, 1);
    repeat (8) cyc();
`else
    repeat (3 * RI) cyc();
    check("no_recal", EXEC_STATE, S_INIT);
    valid = 1; repeat (9) cyc(); valid = 0;
    repeat (3 * RI) cyc();
    check("acq_stays", EXEC_STATE, S_ACQ);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
